// File: rtl/mem_port_arbiter.sv
// Two-master arbiter onto a single memory port: data side has priority,
// instruction fetch is forced through after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_ready,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_d_req,
   input  logic [31:0] i_d_addr,
   input  logic        i_d_wen,
   input  logic [31:0] i_d_wdata,
   input  logic [3:0]  i_d_mask,
   output logic        o_d_ready,
   output logic        o_d_rvalid,
   output logic [31:0] o_d_rdata,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t         state_q, state_d;
   logic           own_d_q, own_d_d;   // 1 = data side owns the transaction
   logic [31:2]    addr_q, addr_d;
   logic           wen_q, wen_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [3:0]     mask_q, mask_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic           grant_if, grant_d, done, issue;

   // Word-aligned downstream: the byte-offset bits are dropped at capture.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_if_addr[1:0], i_d_addr[1:0]};

   always_comb begin
      state_d  = state_q;
      own_d_d  = own_d_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      starve_d = starve_q;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_if_req && (!i_d_req || starve_q == LIMIT)) grant_if = 1'b1;
            else if (i_d_req)                                 grant_d  = 1'b1;
            if (grant_if) begin
               state_d  = ISSUE;
               own_d_d  = 1'b0;
               addr_d   = i_if_addr[31:2];
               wen_d    = 1'b0;
               wdata_d  = '0;
               mask_d   = 4'b1111;
               starve_d = '0;
            end else if (grant_d) begin
               state_d = ISSUE;
               own_d_d = 1'b1;
               addr_d  = i_d_addr[31:2];
               wen_d   = i_d_wen;
               wdata_d = i_d_wdata;
               mask_d  = i_d_mask;
               if (i_if_req && starve_q != LIMIT) starve_d = starve_q + SW'(1);
            end
         end
         ISSUE: begin
            // A response is only meaningful once the request has been accepted.
            if (i_mem_ready) begin
               if (i_mem_rvalid) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_mem_rvalid) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         state_d  = IDLE;
         own_d_d  = 1'b0;
         addr_d   = '0;
         wen_d    = 1'b0;
         wdata_d  = '0;
         mask_d   = '0;
         starve_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      starve_q <= starve_d;
   end

   // Every output is held low while rst is high, regardless of state.
   assign issue       = !rst && (state_q == ISSUE);
   assign o_if_ready  = !rst && grant_if;
   assign o_d_ready   = !rst && grant_d;
   assign o_if_rvalid = !rst && done && !own_d_q;
   assign o_d_rvalid  = !rst && done && own_d_q;
   assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
   assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
   assign o_mem_req   = issue;
   assign o_mem_addr  = issue ? {addr_q, 2'b00} : '0;
   assign o_mem_wen   = issue && wen_q;
   assign o_mem_wdata = issue ? wdata_q : '0;
   assign o_mem_mask  = issue ? mask_q : '0;
   assign o_busy      = !rst && (state_q != IDLE);

endmodule
